stream_mux_4x1: RTL and testbench
=================================

STREAM_MUX_4X1 -- requirements
Module: stream_mux_4x1

Interface
REQ-001 SHALL provide parameter: BITS, 4, data width of every channel.
REQ-002 SHALL provide port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL provide port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide ports: in0, in1, in2, in3  input  BITS each  channel data.
REQ-005 SHALL provide port: in_valid  input  4  bit i = channel i holds data.
REQ-006 SHALL provide port: in_ready  output  4  bit i = channel i accepted this cycle.
REQ-007 SHALL provide port: out  output  BITS  registered selected data.
REQ-008 SHALL provide port: out_sel  output  2  channel index that sourced out.
REQ-009 SHALL provide port: out_valid  output  1  out/out_sel hold a word.
REQ-010 SHALL provide port: out_ready  input  1  downstream accepts when high with out_valid.

Function
REQ-011 SHALL transfer on an input when in_valid[i] and in_ready[i] are both high at a rising edge, and on the output when out_valid and out_ready are both high.
REQ-012 SHALL hold a one-entry output register with states EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-013 SHALL define load-enable = EMPTY, or FULL with out_ready=1 (drain and refill in one cycle).
REQ-014 SHALL assert at most one in_ready bit per cycle, only when load-enable is true and that channel is granted.
REQ-015 SHALL grant by round-robin: search channels starting at pointer ptr, ascending modulo 4, first with in_valid set wins.
REQ-016 SHALL advance ptr to (granted index + 1) mod 4 only on an accepted input; ptr 3 wraps to 0; ptr unchanged otherwise.
REQ-017 SHALL make in_ready combinational from in_valid, ptr, state and out_ready; in_valid SHALL NOT depend on in_ready.
REQ-018 SHALL on accept load out <= in[grant], out_sel <= grant, state -> FULL; latency input accept to out_valid = 1 cycle.
REQ-019 SHALL in FULL with out_ready=1 and no in_valid go to EMPTY; out and out_sel keep last values.
REQ-020 SHALL in FULL with out_ready=0 hold out, out_sel, out_valid stable and drive in_ready=0.
REQ-021 SHALL with in_valid=0 in EMPTY stay EMPTY, no ptr change.
REQ-022 SHALL sustain one word per cycle when out_ready is held high and any in_valid bit is set.

Reset
REQ-023 SHALL on rst=1, asynchronously and without clk, force out_valid=0, out=0, out_sel=0, ptr=0, state EMPTY, in_ready=0.
REQ-024 SHALL discard the stored word and make no partial transfer if rst asserts mid-operation; first grant after release searches from channel 0.

Structure
REQ-025 SHALL place NUM_CH=4, SEL_W=2 and the EMPTY/FULL state encoding in shared package stream_mux_pkg.
REQ-026 SHALL implement grant/pointer logic in sub-module rr_arbiter_4: inputs req[3:0], ptr[1:0]; outputs gnt_idx[1:0], gnt_any.
REQ-027 SHALL keep data path (mux and output register) in stream_mux_4x1.

Verification
REQ-028 SHALL test reset: rst=1 mid-stream with out_valid=1 -> out_valid=0, out=0, in_ready=0 immediately; first grant after release = ch0.
REQ-029 SHALL test single channel: in_valid=4'b0100, in2=4'hA, out_ready=1 -> in_ready=4'b0100 same cycle; next cycle out=A, out_sel=2, out_valid=1.
REQ-030 SHALL test round-robin: in_valid=4'b1111 constant, in0..in3=1,2,3,4, out_ready=1 -> out_sel 0,1,2,3,0 on consecutive cycles, one word per cycle.
REQ-031 SHALL test back-pressure: FULL with out=5, out_ready=0 for 3 cycles, in_valid=4'b1111 -> out stays 5, in_ready=0; on out_ready=1, next grant = ptr.
REQ-032 SHALL test wrap and skip: ptr=3, in_valid=4'b0010 -> grant ch1, ptr becomes 2; ptr=3, in_valid=4'b1001 -> grant ch3, ptr becomes 0.
REQ-033 SHALL test drain to empty: FULL, out_ready=1, in_valid=0 -> out_valid=0 next cycle, out and out_sel unchanged.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// Shared constants, state encoding and pointer helper for the 4:1 stream mux.
package stream_mux_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned SEL_W  = 2;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // Pointer after a grant; the 2-bit add wraps 3 -> 0 on its own.
    function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] idx);
        return idx + SEL_W'(1);
    endfunction

endpackage

// File: rtl/rr_arbiter_4.sv
// Round-robin grant: search from ptr upward modulo 4, first requester wins.
module rr_arbiter_4
    import stream_mux_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [SEL_W-1:0]  gnt_idx,
    output logic              gnt_any
);

    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!gnt_any && req[ptr + SEL_W'(i)]) begin
                gnt_idx = ptr + SEL_W'(i);
                gnt_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_mux_4x1.sv
// Four-channel valid/ready stream multiplexer with round-robin arbitration
// and a single registered output slot.
module stream_mux_4x1
    import stream_mux_pkg::*;
#(
    parameter int unsigned BITS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BITS-1:0]   in0,
    input  logic [BITS-1:0]   in1,
    input  logic [BITS-1:0]   in2,
    input  logic [BITS-1:0]   in3,
    input  logic [NUM_CH-1:0] in_valid,
    output logic [NUM_CH-1:0] in_ready,
    output logic [BITS-1:0]   out,
    output logic [SEL_W-1:0]  out_sel,
    output logic              out_valid,
    input  logic              out_ready
);

    state_t            state;
    state_t            state_next;
    logic [SEL_W-1:0]  ptr;
    logic [SEL_W-1:0]  gnt_idx;
    logic              gnt_any;
    logic              load_en;
    logic              accept;
    logic [BITS-1:0]   sel_data;

    rr_arbiter_4 u_arb (
        .req     (in_valid),
        .ptr     (ptr),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    // Slot may load when empty, or when full and draining this same cycle.
    // in_ready is masked by rst so nothing is offered while in reset.
    always_comb begin
        state_next = state;
        load_en    = 1'b0;
        unique case (state)
            EMPTY: load_en = 1'b1;
            FULL:  load_en = out_ready;
            default: load_en = 1'b0;
        endcase
        accept   = load_en && gnt_any && !rst;
        in_ready = NUM_CH'(accept) << gnt_idx;
        if (accept) begin
            state_next = FULL;
        end else if (state == FULL && out_ready) begin
            state_next = EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        sel_data = in0;
        unique case (gnt_idx)
            2'd0: sel_data = in0;
            2'd1: sel_data = in1;
            2'd2: sel_data = in2;
            2'd3: sel_data = in3;
            default: sel_data = in0;
        endcase
    end

    // Output word and pointer only move on an accepted input; a drain keeps
    // the last word visible with out_valid low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out     <= '0;
            out_sel <= '0;
            ptr     <= '0;
        end else if (accept) begin
            out     <= sel_data;
            out_sel <= gnt_idx;
            ptr     <= next_ptr(gnt_idx);
        end
    end

    assign out_valid = (state == FULL);

endmodule

// File: tb/tb_stream_mux_4x1.sv
// Scoreboarded directed bench for stream_mux_4x1.
module tb_stream_mux_4x1;

    typedef struct packed {
        logic [3:0] data;
        logic [1:0] sel;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [3:0] in0, in1, in2, in3;
    logic [3:0] in_valid;
    logic [3:0] in_ready;
    logic [3:0] out;
    logic [1:0] out_sel;
    logic       out_valid;
    logic       out_ready;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];

    stream_mux_4x1 #(.BITS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in0       (in0),
        .in1       (in1),
        .in2       (in2),
        .in3       (in3),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every output handshake must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_word", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("mon_data", 32'(out), 32'(e.data));
                check("mon_sel",  32'(out_sel), 32'(e.sel));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; out_ready = 1'b0; in_valid = 4'b1111;
        in0 = 4'h0; in1 = 4'h0; in2 = 4'h0; in3 = 4'h0;
        #3;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out",       32'(out), 32'd0);
        check("rst_out_sel",   32'(out_sel), 32'd0);
        check("rst_in_ready",  32'(in_ready), 32'd0);
        in_valid = 4'b0000;
        tick();
        rst = 1'b0;
        tick();

        // Single channel 2
        in2 = 4'hA; in_valid = 4'b0100; out_ready = 1'b1; #1;
        check("single_in_ready", 32'(in_ready), 32'h4);
        sb.push_back('{data: 4'hA, sel: 2'd2});
        tick();
        in_valid = 4'b0000;
        check("single_out_valid", 32'(out_valid), 32'd1);
        check("single_out", 32'(out), 32'hA);
        check("single_out_sel", 32'(out_sel), 32'd2);

        // Drain to empty: word and index persist
        tick();
        check("drain_out_valid", 32'(out_valid), 32'd0);
        check("drain_out", 32'(out), 32'hA);
        check("drain_out_sel", 32'(out_sel), 32'd2);

        // ptr=3, only ch1 requests -> grant 1, ptr -> 2
        in1 = 4'h7; in_valid = 4'b0010; #1;
        check("skip_in_ready", 32'(in_ready), 32'h2);
        sb.push_back('{data: 4'h7, sel: 2'd1});
        tick();
        // ptr=2: ch2 granted (proves ptr moved to 2), ptr -> 3
        in2 = 4'h8; in_valid = 4'b0100; #1;
        check("ptr2_in_ready", 32'(in_ready), 32'h4);
        sb.push_back('{data: 4'h8, sel: 2'd2});
        tick();
        // ptr=3, ch0 and ch3 request -> ch3, ptr wraps to 0; drain+refill
        in0 = 4'h9; in3 = 4'h6; in_valid = 4'b1001; #1;
        check("wrap_in_ready", 32'(in_ready), 32'h8);
        sb.push_back('{data: 4'h6, sel: 2'd3});
        tick();

        // Round robin at full rate starting from ptr=0
        in0 = 4'h1; in1 = 4'h2; in2 = 4'h3; in3 = 4'h4; in_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            logic [3:0] onehot;
            onehot = 4'b0001 << (k % 4);
            #1;
            check("rr_in_ready", 32'(in_ready), 32'(onehot));
            sb.push_back('{data: 4'((k % 4) + 1), sel: 2'(k % 4)});
            tick();
            check("rr_out_valid", 32'(out_valid), 32'd1);
            check("rr_out_sel", 32'(out_sel), 32'(k % 4));
        end

        // Load 5 from ch1 (ptr=1), then stall for three cycles
        in1 = 4'h5; in_valid = 4'b0010; #1;
        check("bp_load_in_ready", 32'(in_ready), 32'h2);
        sb.push_back('{data: 4'h5, sel: 2'd1});
        tick();
        out_ready = 1'b0; in_valid = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_in_ready", 32'(in_ready), 32'd0);
            tick();
            check("bp_out", 32'(out), 32'h5);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_out_sel", 32'(out_sel), 32'd1);
        end
        out_ready = 1'b1; #1;
        check("bp_release_grant", 32'(in_ready), 32'h4);
        sb.push_back('{data: 4'h3, sel: 2'd2});
        tick();
        in_valid = 4'b0000;
        tick();

        // Reset mid-stream with a stored word, ptr sitting at 3
        in2 = 4'hC; in_valid = 4'b0100; out_ready = 1'b0; #1;
        check("pre_rst_in_ready", 32'(in_ready), 32'h4);
        tick();
        in_valid = 4'b1111;
        check("pre_rst_out_valid", 32'(out_valid), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out", 32'(out), 32'd0);
        check("mid_rst_out_sel", 32'(out_sel), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        tick();
        rst = 1'b0; out_ready = 1'b1; #1;
        check("post_rst_grant", 32'(in_ready), 32'h1);
        sb.push_back('{data: 4'h1, sel: 2'd0});
        tick();
        in_valid = 4'b0000;
        check("post_rst_out_sel", 32'(out_sel), 32'd0);
        tick();
        tick();
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
